// File: rtl/timer_tick_scheduler_if.sv
// Avalon-MM slave bus bundle for timer_tick_scheduler.
interface timer_tick_scheduler_if;
  logic        chipselect;
  logic [4:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/timer_tick_scheduler.sv
// Fans the interval-timer tick out to NUM_CH one-shot/periodic event channels.
// Optional tick prescaler enabled by TIMER_TICK_SCHEDULER_PRESCALE_EN.
module timer_tick_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick,
  timer_tick_scheduler_if.slave  bus,
  output logic [NUM_CH-1:0]      expired,
  output logic                   irq
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CH - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StScan = 1'b1;

  localparam logic [4:0] AddrIrqStat  = 5'd16;
  localparam logic [4:0] AddrGstat    = 5'd17;
  localparam logic [4:0] AddrPrescale = 5'd18;

  logic [0:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic [NUM_CH-1:0] en_q, en_d, per_q, per_d, ie_q, ie_d, flag_q, flag_d;
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [15:0]     readdata_q, readdata_d;
  logic [15:0]     rd_data;
  logic            wr, rd, tick_eff, pend_now;

  assign wr = bus.chipselect & ~bus.write_n;
  assign rd = bus.chipselect & bus.write_n;

`ifdef TIMER_TICK_SCHEDULER_PRESCALE_EN
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pre_cnt_q, pre_cnt_d;

  always_comb begin
    tick_eff   = tick && (pre_cnt_q == prescale_q);
    pre_cnt_d  = pre_cnt_q;
    prescale_d = prescale_q;
    if (tick) pre_cnt_d = tick_eff ? '0 : pre_cnt_q + 16'd1;
    if (wr && bus.address == AddrPrescale) begin
      prescale_d = bus.writedata;
      pre_cnt_d  = '0;
    end
  end
`else
  assign tick_eff = tick;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    en_d      = en_q;
    per_d     = per_q;
    ie_d      = ie_q;
    flag_d    = flag_q;
    period_d  = period_q;
    count_d   = count_q;
    expired   = '0;
    pend_now  = pending_q;

    unique case (state_q)
      StIdle: begin
        if (tick_eff || pending_q) begin
          state_d   = StScan;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      StScan: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (idx_q == IdxW'(i) && en_q[i] && period_q[i] != '0) begin
            if (count_q[i] <= CNT_W'(1)) begin
              flag_d[i]  = 1'b1;
              expired[i] = 1'b1;
              if (per_q[i]) begin
                count_d[i] = period_q[i];
              end else begin
                en_d[i]    = 1'b0;
                count_d[i] = '0;
              end
            end else begin
              count_d[i] = count_q[i] - CNT_W'(1);
            end
          end
        end
        // One tick may be queued per scan; a second one is dropped and flagged.
        if (tick_eff) begin
          if (pending_q) overrun_d = 1'b1;
          else           pend_now  = 1'b1;
        end
        if (idx_q == LastIdx) begin
          pending_d = 1'b0;
          idx_d     = '0;
          if (!pend_now) state_d = StIdle;
        end else begin
          pending_d = pend_now;
          idx_d     = idx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus writes override the scan, except that an expiry beats a flag clear.
    if (wr && !bus.address[4]) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.address[3:2] == 2'(i)) begin
          case (bus.address[1:0])
            2'd0: begin
              en_d[i]  = bus.writedata[0];
              per_d[i] = bus.writedata[1];
              ie_d[i]  = bus.writedata[2];
              if (bus.writedata[0] && !en_q[i]) count_d[i] = period_q[i];
            end
            2'd1:    period_d[i] = bus.writedata[CNT_W-1:0];
            2'd2:    count_d[i]  = bus.writedata[CNT_W-1:0];
            default: flag_d[i]   = expired[i];
          endcase
        end
      end
    end
    if (wr && bus.address == AddrGstat) overrun_d = 1'b0;
  end

  always_comb begin
    rd_data = '0;
    if (!bus.address[4]) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.address[3:2] == 2'(i)) begin
          case (bus.address[1:0])
            2'd0:    rd_data = {13'd0, ie_q[i], per_q[i], en_q[i]};
            2'd1:    rd_data = 16'(period_q[i]);
            2'd2:    rd_data = 16'(count_q[i]);
            default: rd_data = {15'd0, flag_q[i]};
          endcase
        end
      end
    end else if (bus.address == AddrIrqStat) begin
      rd_data = 16'(flag_q);
    end else if (bus.address == AddrGstat) begin
      rd_data = {15'd0, overrun_q};
`ifdef TIMER_TICK_SCHEDULER_PRESCALE_EN
    end else if (bus.address == AddrPrescale) begin
      rd_data = prescale_q;
`endif
    end
    readdata_d = rd ? rd_data : readdata_q;
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(flag_q & ie_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      en_q       <= '0;
      per_q      <= '0;
      ie_q       <= '0;
      flag_q     <= '0;
      readdata_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= '0;
        count_q[i]  <= '0;
      end
`ifdef TIMER_TICK_SCHEDULER_PRESCALE_EN
      prescale_q <= '0;
      pre_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      en_q       <= en_d;
      per_q      <= per_d;
      ie_q       <= ie_d;
      flag_q     <= flag_d;
      readdata_q <= readdata_d;
      period_q   <= period_d;
      count_q    <= count_d;
`ifdef TIMER_TICK_SCHEDULER_PRESCALE_EN
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Scoreboard bench for timer_tick_scheduler (NUM_CH=4, CNT_W=16).
module tb_timer_tick_scheduler;

  localparam int unsigned NumCh = 4;

  logic             clk;
  logic             reset_n;
  logic             tick;
  logic [NumCh-1:0] expired;
  logic             irq;

  timer_tick_scheduler_if bus_if ();

  timer_tick_scheduler #(
    .NUM_CH (NumCh),
    .CNT_W  (16)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .bus     (bus_if),
    .expired (expired),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      check_eq(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [15:0] data);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = addr;
    bus_if.writedata  = data;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input string tag, input logic [4:0] addr, input logic [15:0] exp);
    sb_push(tag, {16'd0, exp});
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    bus_if.address    = addr;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    sb_pop_check({16'd0, bus_if.readdata});
  endtask

  // One tick, then the expired vector is checked in each of the NumCh scan slots.
  task automatic do_tick(input string tag, input logic [NumCh-1:0] exp_mask);
    for (int k = 0; k < NumCh; k++) begin
      sb_push(tag, exp_mask[k] ? (32'd1 << k) : 32'd0);
    end
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    for (int k = 0; k < NumCh; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      sb_pop_check({28'd0, expired});
    end
    idle(6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    tick = 1'b0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = '0;
    bus_if.writedata  = '0;
    idle(3);
    check_eq("rst_readdata", {16'd0, bus_if.readdata}, 32'd0);
    check_eq("rst_expired", {28'd0, expired}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    idle(2);
    bus_read("rst_ctrl0", 5'd0, 16'd0);
    bus_read("rst_irqstat", 5'd16, 16'd0);

    // Ch0 periodic, PERIOD=3, irq enabled.
    bus_write(5'd1, 16'd3);
    bus_write(5'd0, 16'h0007);
    bus_read("t1_count_load", 5'd2, 16'd3);
    do_tick("t1_tick1", 4'b0000);
    bus_read("t1_count_t1", 5'd2, 16'd2);
    do_tick("t1_tick2", 4'b0000);
    do_tick("t1_tick3", 4'b0001);
    bus_read("t1_flag", 5'd3, 16'd1);
    check_eq("t1_irq", {31'd0, irq}, 32'd1);
    bus_read("t1_count_reload", 5'd2, 16'd3);
    do_tick("t1_tick4", 4'b0000);
    bus_read("t1_count_t4", 5'd2, 16'd2);
    bus_write(5'd3, 16'd0);
    bus_write(5'd0, 16'd0);
    check_eq("t1_irq_clr", {31'd0, irq}, 32'd0);

    // Ch1 one-shot, PERIOD=2, no irq.
    bus_write(5'd5, 16'd2);
    bus_write(5'd4, 16'h0001);
    do_tick("t2_tick1", 4'b0000);
    do_tick("t2_tick2", 4'b0010);
    do_tick("t2_tick3", 4'b0000);
    do_tick("t2_tick4", 4'b0000);
    do_tick("t2_tick5", 4'b0000);
    bus_read("t2_ctrl", 5'd4, 16'd0);
    bus_read("t2_count", 5'd6, 16'd0);
    bus_read("t2_flag", 5'd7, 16'd1);
    bus_read("t2_irqstat", 5'd16, 16'b0010);
    check_eq("t2_irq", {31'd0, irq}, 32'd0);
    bus_write(5'd7, 16'd0);

    // Back-to-back ticks: second pends, third overruns. Ch2 sees two scans.
    bus_write(5'd9, 16'd5);
    bus_write(5'd8, 16'h0001);
    tick = 1'b1;
    idle(3);
    tick = 1'b0;
    idle(12);
    bus_read("t3_count", 5'd10, 16'd3);
    bus_read("t3_overrun", 5'd17, 16'd1);
    bus_write(5'd17, 16'd0);
    bus_read("t3_overrun_clr", 5'd17, 16'd0);
    bus_write(5'd8, 16'd0);

    // Flag clear in the same cycle as ch0's expiry: the flag survives.
    bus_write(5'd1, 16'd1);
    bus_write(5'd0, 16'h0007);
    for (int k = 0; k < NumCh; k++) sb_push("t4_slot", (k == 0) ? 32'd1 : 32'd0);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = 5'd3;
    bus_if.writedata  = 16'd0;
    sb_pop_check({28'd0, expired});
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    for (int k = 1; k < NumCh; k++) begin
      sb_pop_check({28'd0, expired});
      @(posedge clk);
      #1;
    end
    idle(4);
    bus_read("t4_flag", 5'd3, 16'd1);
    check_eq("t4_irq", {31'd0, irq}, 32'd1);
    bus_write(5'd3, 16'd0);
    bus_read("t4_flag_clr", 5'd3, 16'd0);
    check_eq("t4_irq_clr", {31'd0, irq}, 32'd0);
    bus_write(5'd0, 16'd0);

    // PERIOD=0 freezes ch3's count.
    bus_write(5'd12, 16'h0001);
    bus_write(5'd14, 16'd7);
    for (int n = 0; n < 10; n++) do_tick("t5_tick", 4'b0000);
    bus_read("t5_count", 5'd14, 16'd7);
    bus_read("t5_flag", 5'd15, 16'd0);
    bus_write(5'd20, 16'hffff);
    bus_read("t5_unmapped", 5'd20, 16'd0);

    // Prescaler behaviour on ch0, PERIOD=2 periodic.
    bus_write(5'd18, 16'd1);
    bus_write(5'd1, 16'd2);
    bus_write(5'd0, 16'h0003);
`ifdef TIMER_TICK_SCHEDULER_PRESCALE_EN
    bus_read("t6_prescale", 5'd18, 16'd1);
    do_tick("t6_tick1", 4'b0000);
    do_tick("t6_tick2", 4'b0000);
    do_tick("t6_tick3", 4'b0000);
    do_tick("t6_tick4", 4'b0001);
`else
    bus_read("t6_prescale", 5'd18, 16'd0);
    do_tick("t6_tick1", 4'b0000);
    do_tick("t6_tick2", 4'b0001);
`endif

    // Reset in the middle of a scan clears outputs at once.
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_expired", {28'd0, expired}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    bus_read("rst_mid_ctrl", 5'd0, 16'd0);
    bus_read("rst_mid_count", 5'd2, 16'd0);
    bus_read("rst_mid_irqstat", 5'd16, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
